// File: rtl/zynq_ps_pl_design_if.sv
// AXI4-Lite bus between the PS GP0 master and the PL slave.
interface zynq_ps_pl_design_if;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/zynq_ps_pl_design.sv
// PL subsystem: AXI4-Lite slave decoding a BRAM scratchpad and a LED GPIO register.
module zynq_ps_pl_design #(
    parameter logic [31:0] BRAM_BASE = 32'h4000_0000,
    parameter int unsigned BRAM_AW   = 11,
    parameter logic [31:0] GPIO_BASE = 32'h4120_0000,
    parameter int unsigned LED_W     = 4
) (
    input  logic                  ps_clk,
    input  logic                  ps_rst,
    input  logic                  pl_soft_rst,
    zynq_ps_pl_design_if.slave    s_axi,
    output logic [LED_W-1:0]      led_4bits_tri_o
);

    localparam int unsigned DATA_W     = 32;
    localparam logic [31:0] BRAM_BYTES = 32'd1 << (BRAM_AW + 2);
    localparam logic [31:0] GPIO_BYTES = 32'h0001_0000;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_DEC   = 2'b11;

    typedef enum logic [2:0] {
        TGT_NONE  = 3'd0,
        TGT_BRAM  = 3'd1,
        TGT_GDATA = 3'd2,
        TGT_GTRI  = 3'd3,
        TGT_GNULL = 3'd4
    } tgt_e;

    typedef struct packed {
        logic               wr_rdy;
        logic               bvalid;
        logic [1:0]         bresp;
        logic               arready;
        logic               rd_pend;
        tgt_e               rd_tgt;
        logic [BRAM_AW-1:0] rd_idx;
        logic               rvalid;
        logic [1:0]         rresp;
        logic [DATA_W-1:0]  rdata;
        logic [DATA_W-1:0]  gpio_data;
        logic [DATA_W-1:0]  gpio_tri;
    } st_t;

    function automatic tgt_e decode(input logic [31:0] addr);
        logic [31:0] boff;
        logic [31:0] goff;
        decode = TGT_NONE;
        boff   = addr - BRAM_BASE;
        goff   = addr - GPIO_BASE;
        if (boff < BRAM_BYTES) begin
            decode = TGT_BRAM;
        end else if (goff < GPIO_BYTES) begin
            if (goff[15:2] == 14'd0)      decode = TGT_GDATA;
            else if (goff[15:2] == 14'd1) decode = TGT_GTRI;
            else                          decode = TGT_GNULL;
        end
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                                input logic [DATA_W-1:0] new_v,
                                                input logic [3:0]        strb);
        merge = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merge[8*b +: 8] = new_v[8*b +: 8];
        end
    endfunction

    logic [DATA_W-1:0]  mem [2**BRAM_AW];
    st_t                st_q, st_d;
    tgt_e               wr_tgt, ar_tgt;
    logic [BRAM_AW-1:0] wr_idx;
    logic [DATA_W-1:0]  bram_rd;
    logic               wr_fire, rd_fire, wr_bram, rd_access;

    assign wr_tgt  = decode(s_axi.s_axi_awaddr);
    assign ar_tgt  = decode(s_axi.s_axi_araddr);
    assign wr_idx  = s_axi.s_axi_awaddr[BRAM_AW+1:2];
    assign bram_rd = mem[st_q.rd_idx];
    assign wr_fire = st_q.wr_rdy & s_axi.s_axi_awvalid & s_axi.s_axi_wvalid;
    assign rd_fire = st_q.arready & s_axi.s_axi_arvalid;
    assign wr_bram = wr_fire & (wr_tgt == TGT_BRAM);
    // The single BRAM port serves a same-cycle write first; the read retries next cycle.
    assign rd_access = st_q.rd_pend & ~(wr_bram & (st_q.rd_tgt == TGT_BRAM));

    always_comb begin
        st_d = st_q;

        st_d.wr_rdy = s_axi.s_axi_awvalid & s_axi.s_axi_wvalid & ~st_q.bvalid & ~st_q.wr_rdy;
        if (st_q.bvalid & s_axi.s_axi_bready) st_d.bvalid = 1'b0;
        if (wr_fire) begin
            st_d.bvalid = 1'b1;
            st_d.bresp  = (wr_tgt == TGT_NONE) ? RESP_DEC : RESP_OKAY;
            case (wr_tgt)
                TGT_GDATA: st_d.gpio_data = merge(st_q.gpio_data, s_axi.s_axi_wdata, s_axi.s_axi_wstrb);
                TGT_GTRI:  st_d.gpio_tri  = merge(st_q.gpio_tri,  s_axi.s_axi_wdata, s_axi.s_axi_wstrb);
                default:   ;
            endcase
        end

        st_d.arready = s_axi.s_axi_arvalid & ~st_q.rvalid & ~st_q.arready & ~st_q.rd_pend;
        if (st_q.rvalid & s_axi.s_axi_rready) st_d.rvalid = 1'b0;
        if (rd_access) begin
            st_d.rd_pend = 1'b0;
            st_d.rvalid  = 1'b1;
            st_d.rresp   = (st_q.rd_tgt == TGT_NONE) ? RESP_DEC : RESP_OKAY;
            case (st_q.rd_tgt)
                TGT_BRAM:  st_d.rdata = bram_rd;
                TGT_GDATA: st_d.rdata = st_q.gpio_data;
                TGT_GTRI:  st_d.rdata = st_q.gpio_tri;
                default:   st_d.rdata = '0;
            endcase
        end
        if (rd_fire) begin
            st_d.rd_pend = 1'b1;
            st_d.rd_tgt  = ar_tgt;
            st_d.rd_idx  = s_axi.s_axi_araddr[BRAM_AW+1:2];
        end

        if (pl_soft_rst) st_d = '0;
    end

    always_ff @(posedge ps_clk or posedge ps_rst) begin
        if (ps_rst) st_q <= '0;
        else        st_q <= st_d;
    end

    // BRAM contents survive both resets.
    always_ff @(posedge ps_clk) begin
        if (wr_bram & ~pl_soft_rst) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi.s_axi_wstrb[b]) mem[wr_idx][8*b +: 8] <= s_axi.s_axi_wdata[8*b +: 8];
            end
        end
    end

    assign s_axi.s_axi_awready = st_q.wr_rdy;
    assign s_axi.s_axi_wready  = st_q.wr_rdy;
    assign s_axi.s_axi_bvalid  = st_q.bvalid;
    assign s_axi.s_axi_bresp   = st_q.bresp;
    assign s_axi.s_axi_arready = st_q.arready;
    assign s_axi.s_axi_rvalid  = st_q.rvalid;
    assign s_axi.s_axi_rresp   = st_q.rresp;
    assign s_axi.s_axi_rdata   = st_q.rdata;
    assign led_4bits_tri_o     = st_q.gpio_data[LED_W-1:0];

endmodule

// File: tb/tb_zynq_ps_pl_design.sv
// Randomised AXI4-Lite bench for zynq_ps_pl_design with a transaction-level reference model.
module tb_zynq_ps_pl_design;

    localparam logic [31:0] BRAM_BASE = 32'h4000_0000;
    localparam logic [31:0] GPIO_BASE = 32'h4120_0000;

    logic       ps_clk = 1'b0;
    logic       ps_rst;
    logic       pl_soft_rst;
    logic [3:0] leds;

    zynq_ps_pl_design_if axi();

    zynq_ps_pl_design dut (
        .ps_clk          (ps_clk),
        .ps_rst          (ps_rst),
        .pl_soft_rst     (pl_soft_rst),
        .s_axi           (axi),
        .led_4bits_tri_o (leds)
    );

    always #5 ps_clk = ~ps_clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_bram [int];
    logic [31:0] m_gdata = '0;
    logic [31:0] m_gtri  = '0;
    bit          mon_en  = 0;
    bit          bv_exp  = 0;
    logic [1:0]  bresp_exp = '0;
    bit          rv_exp  = 0;
    logic [31:0] rdata_exp = '0;
    logic [1:0]  rresp_exp = '0;
    bit          rd_pend = 0;
    logic [31:0] rd_addr = '0;
    int          wr_commits = 0;
    bit          wr_hs_m, rd_hs_m;

    // 0 = unmapped, 1 = BRAM, 2 = GPIO
    function automatic int region(input logic [31:0] a);
        if (a >= BRAM_BASE && a < BRAM_BASE + 32'h2000)      return 1;
        if (a >= GPIO_BASE && a < GPIO_BASE + 32'h0001_0000) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] off;
        int          idx;
        off = a & ~32'h3;
        case (region(a))
            1: begin
                idx = int'((off - BRAM_BASE) >> 2);
                return m_bram.exists(idx) ? m_bram[idx] : 32'h0;
            end
            2: begin
                if (off - GPIO_BASE == 32'h0) return m_gdata;
                if (off - GPIO_BASE == 32'h4) return m_gtri;
                return 32'h0;
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] off;
        int          idx;
        off = a & ~32'h3;
        if (region(a) == 1) begin
            idx = int'((off - BRAM_BASE) >> 2);
            m_bram[idx] = bytes_merge(m_bram.exists(idx) ? m_bram[idx] : 32'h0, d, s);
        end else if (region(a) == 2) begin
            if (off - GPIO_BASE == 32'h0) m_gdata = bytes_merge(m_gdata, d, s);
            if (off - GPIO_BASE == 32'h4) m_gtri  = bytes_merge(m_gtri, d, s);
        end
    endtask

    // Per-cycle compare, then advance the model by the events of this cycle.
    initial begin
        forever begin
            @(negedge ps_clk);
            if (mon_en) begin
                chk("led", 32'(leds), 32'(m_gdata[3:0]));
                chk("bvalid", 32'(axi.s_axi_bvalid), 32'(bv_exp));
                if (bv_exp) chk("bresp", 32'(axi.s_axi_bresp), 32'(bresp_exp));
                chk("rvalid", 32'(axi.s_axi_rvalid), 32'(rv_exp));
                if (rv_exp) begin
                    chk("rdata", axi.s_axi_rdata, rdata_exp);
                    chk("rresp", 32'(axi.s_axi_rresp), 32'(rresp_exp));
                end
                chk("aw_w_ready_pair", 32'(axi.s_axi_awready), 32'(axi.s_axi_wready));
                if (axi.s_axi_awready)
                    chk("awready_rule", 32'({axi.s_axi_awvalid, axi.s_axi_wvalid, axi.s_axi_bvalid}), 32'(3'b110));
                if (axi.s_axi_arready)
                    chk("arready_rule", 32'({axi.s_axi_arvalid, axi.s_axi_rvalid, rd_pend}), 32'(3'b100));

                wr_hs_m = axi.s_axi_awvalid && axi.s_axi_awready && axi.s_axi_wvalid && axi.s_axi_wready;
                rd_hs_m = axi.s_axi_arvalid && axi.s_axi_arready;
                if (pl_soft_rst) begin
                    m_gdata = '0; m_gtri = '0;
                    bv_exp  = 0;  rv_exp = 0; rd_pend = 0;
                end else begin
                    if (rv_exp && axi.s_axi_rready) rv_exp = 0;
                    if (rd_pend && !(wr_hs_m && region(axi.s_axi_awaddr) == 1 && region(rd_addr) == 1)) begin
                        rv_exp    = 1;
                        rdata_exp = m_read(rd_addr);
                        rresp_exp = (region(rd_addr) == 0) ? 2'b11 : 2'b00;
                        rd_pend   = 0;
                    end
                    if (rd_hs_m) begin
                        rd_pend = 1;
                        rd_addr = axi.s_axi_araddr;
                    end
                    if (bv_exp && axi.s_axi_bready) bv_exp = 0;
                    if (wr_hs_m) begin
                        bv_exp    = 1;
                        bresp_exp = (region(axi.s_axi_awaddr) == 0) ? 2'b11 : 2'b00;
                        m_write(axi.s_axi_awaddr, axi.s_axi_wdata, axi.s_axi_wstrb);
                        wr_commits++;
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge ps_clk); #1;
    endtask

    task automatic wr_addr_phase(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
        int n;
        bit hs;
        axi.s_axi_awaddr = a;
        axi.s_axi_wdata  = d;
        axi.s_axi_wstrb  = s;
        if (lead >= 0) axi.s_axi_awvalid = 1'b1;
        if (lead <= 0) axi.s_axi_wvalid  = 1'b1;
        repeat ((lead < 0) ? -lead : lead) step();
        axi.s_axi_awvalid = 1'b1;
        axi.s_axi_wvalid  = 1'b1;
        n = 0; hs = 0;
        while (!hs && n < 100) begin
            @(negedge ps_clk); hs = axi.s_axi_awready;
            step(); n++;
        end
        chk("aw_handshake_timeout", 32'(hs), 32'd1);
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wvalid  = 1'b0;
    endtask

    task automatic wr_resp_phase(input int bdly, output logic [1:0] resp);
        int n;
        bit hs;
        repeat (bdly) step();
        axi.s_axi_bready = 1'b1;
        n = 0; hs = 0; resp = 2'bxx;
        while (!hs && n < 100) begin
            @(negedge ps_clk); hs = axi.s_axi_bvalid; resp = axi.s_axi_bresp;
            step(); n++;
        end
        chk("b_handshake_timeout", 32'(hs), 32'd1);
        axi.s_axi_bready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, input int bdly, output logic [1:0] resp);
        wr_addr_phase(a, d, s, lead);
        wr_resp_phase(bdly, resp);
    endtask

    task automatic rd_addr_phase(input logic [31:0] a);
        int n;
        bit hs;
        axi.s_axi_araddr  = a;
        axi.s_axi_arvalid = 1'b1;
        n = 0; hs = 0;
        while (!hs && n < 100) begin
            @(negedge ps_clk); hs = axi.s_axi_arready;
            step(); n++;
        end
        chk("ar_handshake_timeout", 32'(hs), 32'd1);
        axi.s_axi_arvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, input int rdly,
                            output logic [31:0] data, output logic [1:0] resp, output int lat);
        int n;
        bit got;
        rd_addr_phase(a);
        axi.s_axi_rready = (rdly == 0);
        n = 0; lat = -1; got = 0; data = 'x; resp = 'x;
        while (!got && n < 100) begin
            @(negedge ps_clk); n++;
            if (axi.s_axi_rvalid && lat < 0) lat = n;
            if (axi.s_axi_rvalid && axi.s_axi_rready) begin
                got = 1; data = axi.s_axi_rdata; resp = axi.s_axi_rresp;
            end
            step();
            if (n >= rdly) axi.s_axi_rready = 1'b1;
        end
        chk("r_handshake_timeout", 32'(got), 32'd1);
        axi.s_axi_rready = 1'b0;
    endtask

    task automatic soft_pulse();
        pl_soft_rst = 1'b1;
        step();
        pl_soft_rst = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        int unsigned r;
        logic [31:0] lo;
        r  = $urandom_range(0, 12);
        lo = 32'($urandom_range(0, 3));
        if (r < 8)   return BRAM_BASE + 32'(4 * r) + lo;
        if (r == 8)  return BRAM_BASE + 32'h1FFC + lo;
        if (r == 9)  return GPIO_BASE + lo;
        if (r == 10) return GPIO_BASE + 32'h4 + lo;
        if (r == 11) return GPIO_BASE + 32'h8 + lo;
        return ($urandom_range(0, 1) != 0) ? BRAM_BASE + 32'h2000 + lo : GPIO_BASE + 32'h0001_0000 + lo;
    endfunction

    // ---------------- stimulus ----------------
    logic [1:0]  resp;
    logic [31:0] rd;
    int          lat;
    int          commits_before;
    bit          hs;

    initial begin
        ps_rst            = 1'b1;
        pl_soft_rst       = 1'b0;
        axi.s_axi_awaddr  = '0; axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wdata   = '0; axi.s_axi_wstrb   = '0; axi.s_axi_wvalid = 1'b0;
        axi.s_axi_bready  = 1'b0;
        axi.s_axi_araddr  = '0; axi.s_axi_arvalid = 1'b0;
        axi.s_axi_rready  = 1'b0;
        repeat (20) step();
        ps_rst = 1'b0;
        step();

        @(negedge ps_clk);
        chk("rst_leds",    32'(leds), 32'h0);
        chk("rst_awready", 32'(axi.s_axi_awready), 32'h0);
        chk("rst_wready",  32'(axi.s_axi_wready), 32'h0);
        chk("rst_bvalid",  32'(axi.s_axi_bvalid), 32'h0);
        chk("rst_arready", 32'(axi.s_axi_arready), 32'h0);
        chk("rst_rvalid",  32'(axi.s_axi_rvalid), 32'h0);
        chk("rst_rdata",   axi.s_axi_rdata, 32'h0);
        chk("rst_resp",    32'({axi.s_axi_bresp, axi.s_axi_rresp}), 32'h0);
        mon_en = 1;
        step();

        // GPIO_DATA = 5, then soft reset clears it
        axi_write(GPIO_BASE, 32'h5, 4'hF, 0, 0, resp);
        chk("gpio5_bresp", 32'(resp), 32'h0);
        chk("gpio5_led", 32'(leds), 32'h5);
        soft_pulse();
        @(negedge ps_clk);
        chk("soft_rst_led", 32'(leds), 32'h0);
        step();

        // GPIO all ones
        axi_write(GPIO_BASE, 32'hFFFF_FFFF, 4'hF, 0, 0, resp);
        chk("gpioF_bresp", 32'(resp), 32'h0);
        chk("gpioF_led", 32'(leds), 32'hF);
        axi_read(GPIO_BASE, 0, rd, resp, lat);
        chk("gpioF_readback", rd, 32'hFFFF_FFFF);

        // BRAM write/read and read latency
        axi_write(BRAM_BASE, 32'hDEAD_BEEF, 4'hF, 0, 0, resp);
        axi_read(BRAM_BASE, 0, rd, resp, lat);
        chk("bram0_rdata", rd, 32'hDEAD_BEEF);
        chk("bram0_rresp", 32'(resp), 32'h0);
        chk("bram0_latency", 32'(lat), 32'd2);

        // top word with partial strobes, then just past the region
        axi_write(BRAM_BASE + 32'h1FFC, 32'h0, 4'hF, 0, 0, resp);
        axi_write(BRAM_BASE + 32'h1FFC, 32'h1234_5678, 4'b0011, 0, 0, resp);
        axi_read(BRAM_BASE + 32'h1FFC, 0, rd, resp, lat);
        chk("bram_top_strobe", rd, 32'h0000_5678);
        axi_read(BRAM_BASE + 32'h2000, 0, rd, resp, lat);
        chk("decerr_rresp", 32'(resp), 32'h3);
        chk("decerr_rdata", rd, 32'h0);

        // AW three cycles ahead of W, bready held low five cycles
        commits_before = wr_commits;
        axi_write(BRAM_BASE + 32'h4, 32'hA5A5_0001, 4'hF, 3, 5, resp);
        chk("aw_early_commits", 32'(wr_commits - commits_before), 32'd1);
        axi_read(BRAM_BASE + 32'h4, 2, rd, resp, lat);
        chk("aw_early_rdata", rd, 32'hA5A5_0001);

        // W ahead of AW, zero strobe, TRI register, unused GPIO offset, unmapped write
        axi_write(BRAM_BASE + 32'h8, 32'h0BAD_F00D, 4'hF, -2, 1, resp);
        axi_read(BRAM_BASE + 32'h8, 0, rd, resp, lat);
        chk("w_early_rdata", rd, 32'h0BAD_F00D);
        axi_write(GPIO_BASE, 32'h0, 4'h0, 0, 0, resp);
        chk("zero_strb_bresp", 32'(resp), 32'h0);
        chk("zero_strb_led", 32'(leds), 32'hF);
        axi_write(GPIO_BASE + 32'h4, 32'hCAFE_0004, 4'hF, 0, 0, resp);
        axi_read(GPIO_BASE + 32'h4, 0, rd, resp, lat);
        chk("gpio_tri_rdata", rd, 32'hCAFE_0004);
        chk("gpio_tri_led", 32'(leds), 32'hF);
        axi_write(GPIO_BASE + 32'h8, 32'h1111_1111, 4'hF, 0, 0, resp);
        axi_read(GPIO_BASE + 32'h8, 0, rd, resp, lat);
        chk("gpio_null_rdata", rd, 32'h0);
        chk("gpio_null_rresp", 32'(resp), 32'h0);
        axi_write(32'h0000_0010, 32'h2222_2222, 4'hF, 0, 0, resp);
        chk("unmapped_bresp", 32'(resp), 32'h3);

        // soft reset drops a pending write response and a pending read
        wr_addr_phase(BRAM_BASE + 32'hC, 32'h7777_0000, 4'hF, 0);
        step();
        soft_pulse();
        repeat (3) step();
        chk("soft_drop_bvalid", 32'(axi.s_axi_bvalid), 32'h0);
        rd_addr_phase(BRAM_BASE + 32'hC);
        soft_pulse();
        repeat (4) step();
        chk("soft_drop_rvalid", 32'(axi.s_axi_rvalid), 32'h0);

        // soft reset on the handshake cycle: write not committed
        axi_write(GPIO_BASE, 32'h3, 4'hF, 0, 0, resp);
        axi.s_axi_awaddr = GPIO_BASE; axi.s_axi_wdata = 32'hC; axi.s_axi_wstrb = 4'hF;
        axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1;
        hs = 0;
        for (int i = 0; i < 20 && !hs; i++) begin
            step();
            if (axi.s_axi_awready) hs = 1;
        end
        chk("abort_saw_ready", 32'(hs), 32'd1);
        pl_soft_rst = 1'b1;
        step();
        pl_soft_rst = 1'b0; axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
        repeat (2) step();
        chk("abort_bvalid", 32'(axi.s_axi_bvalid), 32'h0);
        axi_read(GPIO_BASE, 0, rd, resp, lat);
        chk("abort_gpio", rd, 32'h0);

        // seed every BRAM word used by the random phase
        for (int w = 0; w < 8; w++) axi_write(BRAM_BASE + 32'(4 * w), 32'h0, 4'hF, 0, 0, resp);
        axi_write(BRAM_BASE + 32'h1FFC, 32'h0, 4'hF, 0, 0, resp);

        // concurrent random writer and reader
        fork
            begin
                logic [1:0] r_w;
                for (int i = 0; i < 60; i++) begin
                    axi_write(pick_addr(), $urandom, 4'($urandom_range(0, 15)),
                              int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)), r_w);
                    repeat ($urandom_range(0, 2)) step();
                end
            end
            begin
                logic [31:0] d_r;
                logic [1:0]  r_r;
                int          l_r;
                for (int i = 0; i < 60; i++) begin
                    axi_read(pick_addr(), int'($urandom_range(0, 3)), d_r, r_r, l_r);
                    repeat ($urandom_range(0, 2)) step();
                end
            end
        join

        repeat (5) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
